// File: rtl/mux_pkg.sv
// Shared constants and helpers for the arbitrated data multiplexer.
package mux_pkg;

  localparam int unsigned MUX_FIXED = 32'd0;
  localparam int unsigned MUX_RR    = 32'd1;

  // Width of a channel index; never narrower than one bit.
  function automatic int unsigned sel_w(input int unsigned n);
    return (n <= 32'd1) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// One-hot arbiter with a rotating priority pointer (held at 0 in fixed mode).
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned MODE     = MUX_RR,
  parameter int unsigned SEL_W    = sel_w(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] req,
  input  logic                update,
  input  logic [SEL_W-1:0]    upd_sel,
  output logic [CHANNELS-1:0] grant
);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] idx;
  logic             found;

  // Search upward from ptr with wrap; first requester found wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      idx = SEL_W'((32'(ptr) + k) % CHANNELS);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  // Pointer moves past the served channel only when a transfer happens.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if ((MODE == MUX_RR) && update) begin
      ptr <= SEL_W'((32'(upd_sel) + 32'd1) % CHANNELS);
    end
  end

endmodule

// File: rtl/arb_mux.sv
// Registered N-to-1 data multiplexer with internal arbitration and valid/ready.
module arb_mux
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned MODE     = MUX_RR,
  parameter int unsigned SEL_W    = sel_w(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_sel,
  input  logic                      out_ready
);

  logic [CHANNELS-1:0] grant;
  logic [WIDTH-1:0]    sel_data;
  logic [SEL_W-1:0]    sel_idx;
  logic                load;
  logic                xfer;

  rr_arbiter #(
    .CHANNELS(CHANNELS),
    .MODE    (MODE)
  ) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (in_valid),
    .update (xfer),
    .upd_sel(sel_idx),
    .grant  (grant)
  );

  // Output register can take a beat when empty or being drained this cycle.
  assign load     = ~out_valid | out_ready;
  assign in_ready = grant & {CHANNELS{load & ~rst}};
  assign xfer     = |(in_valid & in_ready);

  // One-hot AND-OR select of the granted channel's data and index.
  always_comb begin
    sel_data = '0;
    sel_idx  = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (grant[i]) begin
        sel_data = sel_data | in_data[i*WIDTH +: WIDTH];
        sel_idx  = sel_idx | SEL_W'(i);
      end
    end
  end

  // Output stage: load on transfer, empty on idle load, hold during stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (load) begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_sel   <= sel_idx;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arb_mux.sv
// Self-checking bench: round-robin and fixed-priority instances share stimulus.
module tb_arb_mux;

  localparam int unsigned W  = 16;
  localparam int unsigned CH = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [CH-1:0]   in_valid;
  logic [CH*W-1:0] in_data;
  logic            out_ready;

  logic [CH-1:0] rr_in_ready, fp_in_ready;
  logic          rr_out_valid, fp_out_valid;
  logic [W-1:0]  rr_out_data, fp_out_data;
  logic [1:0]    rr_out_sel, fp_out_sel;

  always #5 clk = ~clk;

  arb_mux #(.WIDTH(W), .CHANNELS(CH), .MODE(1)) dut_rr (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rr_in_ready), .out_valid(rr_out_valid), .out_data(rr_out_data),
    .out_sel(rr_out_sel), .out_ready(out_ready)
  );

  arb_mux #(.WIDTH(W), .CHANNELS(CH), .MODE(0)) dut_fp (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(fp_in_ready), .out_valid(fp_out_valid), .out_data(fp_out_data),
    .out_sel(fp_out_sel), .out_ready(out_ready)
  );

  typedef struct packed {
    logic [W-1:0] data;
    logic [1:0]   sel;
  } beat_t;

  beat_t q_rr[$];
  beat_t q_fp[$];
  beat_t exp_b;
  beat_t held;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  int unsigned   m_ptr_rr;
  logic          m_valid_rr, m_valid_fp;
  logic [CH-1:0] exp_ready_rr, exp_ready_fp, obs_ready_rr, obs_ready_fp;
  logic          new_beat_rr, new_beat_fp;
  logic          chk_fp = 1'b0;

  // Reference arbitration: scan from ptr upward with wrap.
  function automatic logic [CH-1:0] model_grant(input logic [CH-1:0] req, input int unsigned ptr);
    logic [CH-1:0] one;
    one = 1;
    for (int unsigned k = 0; k < CH; k++) begin
      if (req[(ptr + k) % CH]) return one << ((ptr + k) % CH);
    end
    return '0;
  endfunction

  function automatic int unsigned onehot_idx(input logic [CH-1:0] g);
    for (int unsigned i = 0; i < CH; i++) if (g[i]) return i;
    return 0;
  endfunction

  task automatic set_data(input logic [W-1:0] base);
    for (int unsigned i = 0; i < CH; i++) in_data[i*W +: W] = base + W'(i);
  endtask

  // One clock: predict grants, queue expected beats, sample in_ready mid-cycle.
  task automatic drive_cycle();
    logic [CH-1:0] g;
    int unsigned   idx;
    beat_t         b;
    @(negedge clk);
    obs_ready_rr = rr_in_ready;
    obs_ready_fp = fp_in_ready;
    g = model_grant(in_valid, m_ptr_rr);
    exp_ready_rr = (!m_valid_rr || out_ready) ? g : '0;
    new_beat_rr  = |exp_ready_rr;
    if (new_beat_rr) begin
      idx    = onehot_idx(exp_ready_rr);
      b.data = in_data[idx*W +: W];
      b.sel  = 2'(idx);
      q_rr.push_back(b);
      m_ptr_rr   = (idx + 1) % CH;
      m_valid_rr = 1'b1;
    end else if (!m_valid_rr || out_ready) begin
      m_valid_rr = 1'b0;
    end
    g = model_grant(in_valid, 0);
    exp_ready_fp = (!m_valid_fp || out_ready) ? g : '0;
    new_beat_fp  = |exp_ready_fp;
    if (new_beat_fp) begin
      idx    = onehot_idx(exp_ready_fp);
      b.data = in_data[idx*W +: W];
      b.sel  = 2'(idx);
      if (chk_fp) q_fp.push_back(b);
      m_valid_fp = 1'b1;
    end else if (!m_valid_fp || out_ready) begin
      m_valid_fp = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = '1; in_data = '0; out_ready = 1'b0;
    m_ptr_rr = 0; m_valid_rr = 1'b0; m_valid_fp = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (rr_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b want 0", rr_out_valid); end
    n_checks++; if (rr_out_data !== 16'h0) begin n_fail++; $display("FAIL reset out_data: got %h want 0000", rr_out_data); end
    n_checks++; if (rr_out_sel !== 2'd0) begin n_fail++; $display("FAIL reset out_sel: got %0d want 0", rr_out_sel); end
    n_checks++; if (rr_in_ready !== 4'b0000) begin n_fail++; $display("FAIL reset in_ready: got %b want 0000", rr_in_ready); end
    n_checks++; if (fp_in_ready !== 4'b0000 || fp_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset fp: got ready %b valid %b want 0000 0", fp_in_ready, fp_out_valid); end
    rst = 1'b0;
  endtask

  task automatic test_rr_all();
    set_data(16'hC000); in_valid = 4'b1111; out_ready = 1'b1;
    for (int unsigned k = 0; k < 5; k++) begin
      drive_cycle();
      n_checks++; if (obs_ready_rr !== exp_ready_rr) begin n_fail++; $display("FAIL rr_all in_ready[%0d]: got %b want %b", k, obs_ready_rr, exp_ready_rr); end
      n_checks++; if (rr_out_valid !== 1'b1) begin n_fail++; $display("FAIL rr_all out_valid[%0d]: got %b want 1", k, rr_out_valid); end
      exp_b = q_rr.pop_front();
      n_checks++; if (rr_out_sel !== exp_b.sel || rr_out_sel !== 2'(k % CH)) begin n_fail++; $display("FAIL rr_all sel[%0d]: got %0d want %0d", k, rr_out_sel, k % CH); end
      n_checks++; if (rr_out_data !== exp_b.data || rr_out_data !== 16'hC000 + 16'(k % CH)) begin n_fail++; $display("FAIL rr_all data[%0d]: got %h want %h", k, rr_out_data, 16'hC000 + 16'(k % CH)); end
    end
  endtask

  task automatic test_single();
    in_data = '0; in_data[2*W +: W] = 16'hBEEF; in_valid = 4'b0100; out_ready = 1'b1;
    drive_cycle();
    n_checks++; if (obs_ready_rr !== 4'b0100 || exp_ready_rr !== 4'b0100) begin n_fail++; $display("FAIL single in_ready: got %b want 0100", obs_ready_rr); end
    n_checks++; if (rr_out_valid !== 1'b1) begin n_fail++; $display("FAIL single out_valid: got %b want 1", rr_out_valid); end
    exp_b = q_rr.pop_front();
    n_checks++; if (rr_out_data !== 16'hBEEF || rr_out_data !== exp_b.data) begin n_fail++; $display("FAIL single data: got %h want beef", rr_out_data); end
    n_checks++; if (rr_out_sel !== 2'd2 || rr_out_sel !== exp_b.sel) begin n_fail++; $display("FAIL single sel: got %0d want 2", rr_out_sel); end
    in_valid = 4'b0000;
    drive_cycle();
    n_checks++; if (obs_ready_rr !== 4'b0000) begin n_fail++; $display("FAIL single idle in_ready: got %b want 0000", obs_ready_rr); end
    n_checks++; if (rr_out_valid !== 1'b0 || m_valid_rr !== 1'b0) begin n_fail++; $display("FAIL single drop out_valid: got %b want 0", rr_out_valid); end
  endtask

  task automatic test_stall();
    set_data(16'h5A00); in_valid = 4'b1111; out_ready = 1'b1;
    drive_cycle();
    held = q_rr.pop_front();
    n_checks++; if (rr_out_valid !== 1'b1 || rr_out_sel !== held.sel || rr_out_data !== held.data) begin n_fail++; $display("FAIL stall load: got %b %0d %h want 1 %0d %h", rr_out_valid, rr_out_sel, rr_out_data, held.sel, held.data); end
    out_ready = 1'b0;
    for (int unsigned k = 0; k < 3; k++) begin
      drive_cycle();
      n_checks++; if (obs_ready_rr !== 4'b0000) begin n_fail++; $display("FAIL stall in_ready[%0d]: got %b want 0000", k, obs_ready_rr); end
      n_checks++; if (rr_out_valid !== 1'b1 || rr_out_data !== held.data || rr_out_sel !== held.sel) begin n_fail++; $display("FAIL stall hold[%0d]: got %b %h %0d want 1 %h %0d", k, rr_out_valid, rr_out_data, rr_out_sel, held.data, held.sel); end
    end
    out_ready = 1'b1;
    drive_cycle();
    n_checks++; if (obs_ready_rr !== exp_ready_rr || obs_ready_rr === 4'b0000) begin n_fail++; $display("FAIL stall release in_ready: got %b want %b", obs_ready_rr, exp_ready_rr); end
    exp_b = q_rr.pop_front();
    n_checks++; if (rr_out_valid !== 1'b1 || rr_out_sel !== exp_b.sel || rr_out_data !== exp_b.data) begin n_fail++; $display("FAIL stall release beat: got %b %0d %h want 1 %0d %h", rr_out_valid, rr_out_sel, rr_out_data, exp_b.sel, exp_b.data); end
    in_valid = 4'b0000;
    drive_cycle();
    n_checks++; if (rr_out_valid !== 1'b0) begin n_fail++; $display("FAIL stall drain out_valid: got %b want 0", rr_out_valid); end
  endtask

  task automatic test_fixed();
    chk_fp = 1'b1;
    in_data = '0; in_data[1*W +: W] = 16'h1111; in_data[3*W +: W] = 16'h3333;
    in_valid = 4'b1010; out_ready = 1'b1;
    for (int unsigned k = 0; k < 4; k++) begin
      drive_cycle();
      n_checks++; if (obs_ready_fp !== 4'b0010) begin n_fail++; $display("FAIL fixed in_ready[%0d]: got %b want 0010", k, obs_ready_fp); end
      exp_b = q_fp.pop_front();
      n_checks++; if (fp_out_valid !== 1'b1 || fp_out_sel !== 2'd1 || fp_out_data !== 16'h1111 || fp_out_sel !== exp_b.sel) begin n_fail++; $display("FAIL fixed beat[%0d]: got %b %0d %h want 1 1 1111", k, fp_out_valid, fp_out_sel, fp_out_data); end
      exp_b = q_rr.pop_front();
      n_checks++; if (rr_out_sel !== exp_b.sel || rr_out_data !== exp_b.data) begin n_fail++; $display("FAIL fixed rr beat[%0d]: got %0d %h want %0d %h", k, rr_out_sel, rr_out_data, exp_b.sel, exp_b.data); end
    end
    in_valid = 4'b1000;
    drive_cycle();
    exp_b = q_fp.pop_front();
    n_checks++; if (fp_out_sel !== 2'd3 || fp_out_data !== 16'h3333 || fp_out_data !== exp_b.data) begin n_fail++; $display("FAIL fixed unstarve: got %0d %h want 3 3333", fp_out_sel, fp_out_data); end
    exp_b = q_rr.pop_front();
    n_checks++; if (rr_out_sel !== 2'd3 || rr_out_sel !== exp_b.sel) begin n_fail++; $display("FAIL fixed rr last: got %0d want 3", rr_out_sel); end
    chk_fp = 1'b0;
  endtask

  task automatic test_wrap();
    in_data = '0; in_data[0*W +: W] = 16'h0A0A; in_data[3*W +: W] = 16'h3B3B;
    in_valid = 4'b1001; out_ready = 1'b1;
    drive_cycle();
    n_checks++; if (obs_ready_rr !== 4'b0001) begin n_fail++; $display("FAIL wrap in_ready: got %b want 0001", obs_ready_rr); end
    exp_b = q_rr.pop_front();
    n_checks++; if (rr_out_sel !== 2'd0 || rr_out_data !== 16'h0A0A || rr_out_data !== exp_b.data) begin n_fail++; $display("FAIL wrap first: got %0d %h want 0 0a0a", rr_out_sel, rr_out_data); end
    drive_cycle();
    exp_b = q_rr.pop_front();
    n_checks++; if (rr_out_sel !== 2'd3 || rr_out_data !== 16'h3B3B || rr_out_sel !== exp_b.sel) begin n_fail++; $display("FAIL wrap second: got %0d %h want 3 3b3b", rr_out_sel, rr_out_data); end
  endtask

  task automatic test_async_reset();
    set_data(16'h7700); in_valid = 4'b1111; out_ready = 1'b1;
    drive_cycle();
    exp_b = q_rr.pop_front();
    n_checks++; if (rr_out_valid !== 1'b1 || rr_out_sel !== exp_b.sel) begin n_fail++; $display("FAIL areset pre: got %b %0d want 1 %0d", rr_out_valid, rr_out_sel, exp_b.sel); end
    #3;
    rst = 1'b1;
    #1;
    n_checks++; if (rr_out_valid !== 1'b0 || fp_out_valid !== 1'b0) begin n_fail++; $display("FAIL areset out_valid: got %b %b want 0 0", rr_out_valid, fp_out_valid); end
    n_checks++; if (rr_in_ready !== 4'b0000 || fp_in_ready !== 4'b0000) begin n_fail++; $display("FAIL areset in_ready: got %b %b want 0000 0000", rr_in_ready, fp_in_ready); end
    m_ptr_rr = 0; m_valid_rr = 1'b0; m_valid_fp = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive_cycle();
    n_checks++; if (obs_ready_rr !== 4'b0001) begin n_fail++; $display("FAIL areset first grant: got %b want 0001", obs_ready_rr); end
    exp_b = q_rr.pop_front();
    n_checks++; if (rr_out_sel !== 2'd0 || rr_out_data !== 16'h7700 || rr_out_data !== exp_b.data) begin n_fail++; $display("FAIL areset first beat: got %0d %h want 0 7700", rr_out_sel, rr_out_data); end
    in_valid = 4'b0000;
    drive_cycle();
    n_checks++; if (rr_out_valid !== 1'b0) begin n_fail++; $display("FAIL areset drain: got %b want 0", rr_out_valid); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rr_all();
    test_single();
    test_stall();
    test_fixed();
    test_wrap();
    test_async_reset();
    n_checks++; if (q_rr.size() != 0 || q_fp.size() != 0) begin n_fail++; $display("FAIL scoreboard leftover: got %0d %0d want 0 0", q_rr.size(), q_fp.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
